// File: rtl/hamming_secded_pkg.sv
// Shared types and sizing helpers for the SECDED Hamming codec family.
// Codeword layout: bit 0 overall parity, bits 2^k check bits, data ascending from bit 3.
package hamming_secded_pkg;

   typedef enum logic [1:0] {CLEAN, SEC, DED} ecc_class_t;

   function automatic int calc_checkb(input int width);
      int r;
      r = 0;
      for (int i = 30; i >= 1; i--) begin
         if ((1 << i) >= width + i + 1) r = i;
      end
      return r;
   endfunction

   function automatic int data_pos(input int i);
      int pos;
      int cnt;
      pos = 0;
      cnt = 0;
      // Walk non-power-of-two positions; 2*i+8 always covers the i-th one.
      for (int p = 3; p <= 2 * i + 8; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == i && pos == 0) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED decode: syndrome, overall parity, classification and data correction.
module hamming_secded_core
   import hamming_secded_pkg::*;
#(
   parameter int DATA_WIDTH = 11,
   localparam int N_CHECKB = calc_checkb(DATA_WIDTH),
   localparam int CW_WIDTH = DATA_WIDTH + N_CHECKB + 1
) (
   input  logic [CW_WIDTH-1:0]   hv_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  sec_o,
   output logic                  ded_o,
   output logic [N_CHECKB-1:0]   syndrome_o
);

   localparam logic [N_CHECKB:0] CW_LIM = (N_CHECKB + 1)'(CW_WIDTH);

   function automatic logic [CW_WIDTH-1:0] cover_mask(input int k);
      logic [CW_WIDTH-1:0] m;
      m = '0;
      for (int p = 1; p < CW_WIDTH; p++) m[p] = ((p >> k) & 1) != 0;
      return m;
   endfunction

   logic       par;
   ecc_class_t cls;

   for (genvar gi = 0; gi < N_CHECKB; gi++) begin : g_syn
      assign syndrome_o[gi] = ^(hv_i & cover_mask(gi));
   end

   assign par = ^hv_i;

   // Odd parity with an out-of-range syndrome can only be a multi-bit error.
   always_comb begin
      cls = CLEAN;
      if (par) begin
         cls = ({1'b0, syndrome_o} < CW_LIM) ? SEC : DED;
      end else if (syndrome_o != '0) begin
         cls = DED;
      end
   end

   assign sec_o = (cls == SEC);
   assign ded_o = (cls == DED);

   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
      localparam int DP = data_pos(gi);
      assign data_o[gi] = hv_i[DP] ^ (sec_o && (syndrome_o == N_CHECKB'(DP)));
   end

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined SECDED decoder with valid/ready handshake, saturating SEC/DED counters and sticky flags.
// Optional error-syndrome log enabled by defining HAMMING_SECDED_ERR_LOG_EN.
module hamming_secded_dec_pipe
   import hamming_secded_pkg::*;
#(
   parameter int DATA_WIDTH  = 11,
   parameter int COUNT_WIDTH = 16,
   localparam int N_CHECKB = calc_checkb(DATA_WIDTH),
   localparam int CW_WIDTH = DATA_WIDTH + N_CHECKB + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [CW_WIDTH-1:0]    hv_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   sec_o,
   output logic                   ded_o,
`ifdef HAMMING_SECDED_ERR_LOG_EN
   output logic [N_CHECKB-1:0]    err_syn_o,
   output logic                   err_log_valid_o,
`endif
   input  logic                   clear_i,
   output logic [COUNT_WIDTH-1:0] sec_cnt_o,
   output logic [COUNT_WIDTH-1:0] ded_cnt_o,
   output logic                   sec_sticky_o,
   output logic                   ded_sticky_o
);

   logic [DATA_WIDTH-1:0] core_data;
   logic                  core_sec;
   logic                  core_ded;
   logic [N_CHECKB-1:0]   syn;

   hamming_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .hv_i       (hv_i),
      .data_o     (core_data),
      .sec_o      (core_sec),
      .ded_o      (core_ded),
      .syndrome_o (syn)
   );

   logic                  accept;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  sec_q, sec_d;
   logic                  ded_q, ded_d;

   assign in_ready_o = ~out_valid_q | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      out_valid_d = out_valid_q;
      data_d      = data_q;
      sec_d       = sec_q;
      ded_d       = ded_q;
      if (accept) begin
         out_valid_d = 1'b1;
         data_d      = core_data;
         sec_d       = core_sec;
         ded_d       = core_ded;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         sec_q       <= 1'b0;
         ded_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         sec_q       <= sec_d;
         ded_q       <= ded_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign data_o      = data_q;
   assign sec_o       = sec_q;
   assign ded_o       = ded_q;

   // Index 0 tracks SEC events, index 1 tracks DED events.
   logic [1:0]                  evt;
   logic [1:0][COUNT_WIDTH-1:0] cnt_w;
   logic [1:0]                  sticky_w;

   assign evt = {accept & core_ded, accept & core_sec};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                   sticky_q, sticky_d;

      always_comb begin
         cnt_d    = cnt_q;
         sticky_d = sticky_q;
         if (clear_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
         end else if (evt[gi]) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
         end
      end

      assign cnt_w[gi]    = cnt_q;
      assign sticky_w[gi] = sticky_q;
   end

   assign sec_cnt_o    = cnt_w[0];
   assign ded_cnt_o    = cnt_w[1];
   assign sec_sticky_o = sticky_w[0];
   assign ded_sticky_o = sticky_w[1];

`ifdef HAMMING_SECDED_ERR_LOG_EN
   logic [N_CHECKB-1:0] err_syn_q, err_syn_d;
   logic                log_valid_q, log_valid_d;

   // Only the first event after a clear is captured; later events leave the log frozen.
   always_comb begin
      err_syn_d   = err_syn_q;
      log_valid_d = log_valid_q;
      if (clear_i) begin
         err_syn_d   = '0;
         log_valid_d = 1'b0;
      end else if (!log_valid_q && (evt != 2'b00)) begin
         err_syn_d   = syn;
         log_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_syn_q   <= '0;
         log_valid_q <= 1'b0;
      end else begin
         err_syn_q   <= err_syn_d;
         log_valid_q <= log_valid_d;
      end
   end

   assign err_syn_o       = err_syn_q;
   assign err_log_valid_o = log_valid_q;
`else
   logic unused_syn;
   assign unused_syn = ^syn;
`endif

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Scoreboard bench for hamming_secded_dec_pipe: an 11-bit instance with 2-bit counters and a 32-bit instance.
module tb_hamming_secded_dec_pipe;

   typedef struct packed {
      logic [31:0] data;
      logic        sec;
      logic        ded;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   // Instance A: DATA_WIDTH=11, COUNT_WIDTH=2
   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, clear_a;
   logic [15:0] hv_a;
   logic [10:0] data_a;
   logic        sec_a, ded_a, sec_st_a, ded_st_a;
   logic [1:0]  sec_cnt_a, ded_cnt_a;

   // Instance B: DATA_WIDTH=32, COUNT_WIDTH=16
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, clear_b;
   logic [38:0] hv_b;
   logic [31:0] data_b;
   logic        sec_b, ded_b, sec_st_b, ded_st_b;
   logic [15:0] sec_cnt_b, ded_cnt_b;

`ifdef HAMMING_SECDED_ERR_LOG_EN
   logic [3:0] err_syn_a;
   logic       err_lv_a;
   logic [5:0] err_syn_b;
   logic       err_lv_b;
`endif

   hamming_secded_dec_pipe #(.DATA_WIDTH(11), .COUNT_WIDTH(2)) dut_a (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
      .hv_i(hv_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready_a),
      .data_o(data_a), .sec_o(sec_a), .ded_o(ded_a), .clear_i(clear_a),
      .sec_cnt_o(sec_cnt_a), .ded_cnt_o(ded_cnt_a),
      .sec_sticky_o(sec_st_a), .ded_sticky_o(ded_st_a)
`ifdef HAMMING_SECDED_ERR_LOG_EN
      , .err_syn_o(err_syn_a), .err_log_valid_o(err_lv_a)
`endif
   );

   hamming_secded_dec_pipe #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut_b (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
      .hv_i(hv_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
      .data_o(data_b), .sec_o(sec_b), .ded_o(ded_b), .clear_i(clear_b),
      .sec_cnt_o(sec_cnt_b), .ded_cnt_o(ded_cnt_b),
      .sec_sticky_o(sec_st_b), .ded_sticky_o(ded_st_b)
`ifdef HAMMING_SECDED_ERR_LOG_EN
      , .err_syn_o(err_syn_b), .err_log_valid_o(err_lv_b)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   // Reference encoder for the 32-bit instance, built straight from the codeword layout.
   function automatic logic [38:0] enc32(input logic [31:0] d);
      logic [38:0] c;
      int j;
      c = '0;
      j = 0;
      for (int p = 3; p < 39; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[j];
            j++;
         end
      end
      for (int k = 0; k < 6; k++) begin
         logic b;
         b = 1'b0;
         for (int p = 1; p < 39; p++) if (p[k]) b ^= c[p];
         c[1 << k] = b;
      end
      c[0] = ^c;
      return c;
   endfunction

   // Drive at a falling edge, decide acceptance 1 time unit later; valid stays high on return.
   task automatic send_a(input logic [15:0] cw, input logic [10:0] d, input logic s,
                         input logic e, input logic clr);
      int waits;
      waits = 0;
      @(negedge clk);
      in_valid_a = 1'b1;
      hv_a       = cw;
      clear_a    = clr;
      #1;
      while (!in_ready_a && waits < 20) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!in_ready_a) begin
         tests++;
         fails++;
         $display("FAIL a_send_timeout: in_ready %0b required 1", in_ready_a);
      end else begin
         q_a.push_back({32'(d), s, e});
      end
   endtask

   task automatic drop_a();
      @(negedge clk);
      in_valid_a = 1'b0;
      clear_a    = 1'b0;
   endtask

   task automatic send_b(input logic [38:0] cw, input logic [31:0] d, input logic s, input logic e);
      int waits;
      waits = 0;
      @(negedge clk);
      in_valid_b = 1'b1;
      hv_b       = cw;
      #1;
      while (!in_ready_b && waits < 20) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (!in_ready_b) begin
         tests++;
         fails++;
         $display("FAIL b_send_timeout: in_ready %0b required 1", in_ready_b);
      end else begin
         q_b.push_back({d, s, e});
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t ea;
      #2;
      if (!rst && out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL a_unexpected: data %0h with empty scoreboard", data_a);
         end else begin
            ea = q_a.pop_front();
            check("a_data", 64'(data_a), 64'(ea.data));
            check("a_sec", 64'(sec_a), 64'(ea.sec));
            check("a_ded", 64'(ded_a), 64'(ea.ded));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t eb;
      #2;
      if (!rst && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL b_unexpected: data %0h with empty scoreboard", data_b);
         end else begin
            eb = q_b.pop_front();
            check("b_data", 64'(data_b), 64'(eb.data));
            check("b_sec", 64'(sec_b), 64'(eb.sec));
            check("b_ded", 64'(ded_b), 64'(eb.ded));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [38:0] cw;
      int unsigned pos;

      rst = 1'b1;
      in_valid_a = 1'b0; hv_a = '0; out_ready_a = 1'b0; clear_a = 1'b0;
      in_valid_b = 1'b0; hv_b = '0; out_ready_b = 1'b0; clear_b = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid_a), 64'd0);
      check("rst_data", 64'(data_a), 64'd0);
      check("rst_sec", 64'(sec_a), 64'd0);
      check("rst_ded", 64'(ded_a), 64'd0);
      check("rst_sec_cnt", 64'(sec_cnt_a), 64'd0);
      check("rst_ded_cnt", 64'(ded_cnt_a), 64'd0);
      check("rst_sec_sticky", 64'(sec_st_a), 64'd0);
      check("rst_ded_sticky", 64'(ded_st_a), 64'd0);
      check("rst_in_ready", 64'(in_ready_a), 64'd1);
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;

      // Clean all-ones word
      send_a(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 1'b0);
      drop_a();
      #1;
      check("clean_sec_cnt", 64'(sec_cnt_a), 64'd0);
      check("clean_ded_cnt", 64'(ded_cnt_a), 64'd0);

      // Data bit at position 3 flipped on the zero word
      send_a(16'h0008, 11'h000, 1'b1, 1'b0, 1'b0);
      drop_a();
      #1;
      check("sec1_cnt", 64'(sec_cnt_a), 64'd1);
      check("sec1_sticky", 64'(sec_st_a), 64'd1);
      check("sec1_ded_sticky", 64'(ded_st_a), 64'd0);

      // Back-to-back: parity-bit flip, double flip, clean 11'h001, data flip, check-bit double flip
      send_a(16'h0001, 11'h000, 1'b1, 1'b0, 1'b0);
      send_a(16'h0018, 11'h001, 1'b0, 1'b1, 1'b0);
      send_a(16'h000F, 11'h001, 1'b0, 1'b0, 1'b0);
      send_a(16'hFFDF, 11'h7FF, 1'b1, 1'b0, 1'b0);
      send_a(16'hFFF9, 11'h7FF, 1'b0, 1'b1, 1'b0);
      drop_a();
      #1;
      check("burst_sec_cnt", 64'(sec_cnt_a), 64'd3);
      check("burst_ded_cnt", 64'(ded_cnt_a), 64'd2);
      check("burst_ded_sticky", 64'(ded_st_a), 64'd1);

      // Fourth and fifth SEC words: 2-bit counter must stay saturated
      send_a(16'h0008, 11'h000, 1'b1, 1'b0, 1'b0);
      send_a(16'h0008, 11'h000, 1'b1, 1'b0, 1'b0);
      drop_a();
      #1;
      check("sat_sec_cnt", 64'(sec_cnt_a), 64'd3);
      check("sat_ded_cnt", 64'(ded_cnt_a), 64'd2);

      // Backpressure: hold the first word three cycles, then release
      @(negedge clk);
      out_ready_a = 1'b0;
      send_a(16'h000F, 11'h001, 1'b0, 1'b0, 1'b0);
      fork
         send_a(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 1'b0);
         begin
            repeat (3) begin
               @(negedge clk);
               #1;
               check("bp_in_ready", 64'(in_ready_a), 64'd0);
               check("bp_out_valid", 64'(out_valid_a), 64'd1);
               check("bp_data_hold", 64'(data_a), 64'h001);
            end
            @(negedge clk);
            out_ready_a = 1'b1;
         end
      join
      drop_a();
      #1;
      check("bp_no_bubble_valid", 64'(out_valid_a), 64'd1);
      check("bp_no_bubble_data", 64'(data_a), 64'h7FF);

      // Clear in the same cycle as a SEC accept: event is lost
      send_a(16'h0008, 11'h000, 1'b1, 1'b0, 1'b1);
      drop_a();
      #1;
      check("clr_sec_cnt", 64'(sec_cnt_a), 64'd0);
      check("clr_sec_sticky", 64'(sec_st_a), 64'd0);
      check("clr_ded_cnt", 64'(ded_cnt_a), 64'd0);
      check("clr_ded_sticky", 64'(ded_st_a), 64'd0);
      send_a(16'h0001, 11'h000, 1'b1, 1'b0, 1'b0);
      drop_a();
      #1;
      check("post_clr_sec_cnt", 64'(sec_cnt_a), 64'd1);
      check("post_clr_sec_sticky", 64'(sec_st_a), 64'd1);

      // Reset while a word is held at the output
      @(negedge clk);
      out_ready_a = 1'b0;
      send_a(16'h000F, 11'h001, 1'b0, 1'b0, 1'b0);
      drop_a();
      #1;
      check("held_out_valid", 64'(out_valid_a), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      q_a.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid_a), 64'd0);
      check("midrst_data", 64'(data_a), 64'd0);
      check("midrst_sec_cnt", 64'(sec_cnt_a), 64'd0);
      check("midrst_sec_sticky", 64'(sec_st_a), 64'd0);
      check("midrst_in_ready", 64'(in_ready_a), 64'd1);
      out_ready_a = 1'b1;

      // 32-bit instance: single flips anywhere are corrected
      for (int i = 0; i < 12; i++) begin
         d   = $urandom;
         pos = $urandom_range(0, 38);
         cw  = enc32(d) ^ (39'd1 << pos);
         send_b(cw, d, 1'b1, 1'b0);
      end
      d = 32'hA5A5_0F0F;
      send_b(enc32(d), d, 1'b0, 1'b0);
      send_b(enc32(d) ^ 39'h28, d ^ 32'h3, 1'b0, 1'b1);
      send_b(enc32(d) ^ ((39'd1 << 15) | (39'd1 << 16) | (39'd1 << 32)), d ^ 32'h400, 1'b0, 1'b1);
      @(negedge clk);
      in_valid_b = 1'b0;
      #1;
      check("w32_sec_cnt", 64'(sec_cnt_b), 64'd12);
      check("w32_ded_cnt", 64'(ded_cnt_b), 64'd2);
      check("w32_sec_sticky", 64'(sec_st_b), 64'd1);
      check("w32_ded_sticky", 64'(ded_st_b), 64'd1);

      repeat (4) @(negedge clk);
      #3;
      check("a_scoreboard_drained", 64'(q_a.size()), 64'd0);
      check("b_scoreboard_drained", 64'(q_b.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hamming_secded_dec_pipe.md
Name: hamming_secded_dec_pipe

Overview:
Parametrised SECDED Hamming decoder for any data width, with one registered pipeline stage and a valid/ready handshake on both sides. It corrects single-bit errors and flags double-bit errors, per word. It also keeps saturating SEC/DED event counters and sticky flags for the SafeSU monitor registers. It sits between a protected storage element (register file, counter bank) and its consumer.

Parameters:
DATA_WIDTH, 11, number of payload bits (≥4).
N_CHECKB, derived localparam, smallest r with 2^r ≥ DATA_WIDTH+r+1 (4 for 11, 6 for 32).
CW_WIDTH, derived localparam, DATA_WIDTH+N_CHECKB+1 (16 for 11).
COUNT_WIDTH, 16, width of each saturating error counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  codeword valid
in_ready_o  out  1  stage can accept
hv_i  in  CW_WIDTH  encoded codeword
out_valid_o  out  1  decoded word valid
out_ready_i  in  1  consumer accepts
data_o  out  DATA_WIDTH  corrected data
sec_o  out  1  single error corrected (qualified by out_valid_o)
ded_o  out  1  uncorrectable error (qualified by out_valid_o)
clear_i  in  1  clear counters and sticky flags
sec_cnt_o  out  COUNT_WIDTH  saturating SEC count
ded_cnt_o  out  COUNT_WIDTH  saturating DED count
sec_sticky_o  out  1  SEC seen since clear
ded_sticky_o  out  1  DED seen since clear

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Codeword layout:
  - bit 0 = overall even parity over all bits.
  - Bits 2^k (1, 2, 4, ...) = check bits.
  - Remaining positions hold data bits in ascending order (data[0] at pos 3).
- Decode is combinational on hv_i:
  - syndrome[k] = XOR of hv_i[p] over all p≥1 with bit k of p set.
  - par = XOR of all of hv_i.
- Classification:
  - par=0, syn=0: clean.
  - par=1, syn=0: bit 0 flipped. sec=1, data unchanged.
  - par=1, 0<syn<CW_WIDTH: flip hv_i[syn]. sec=1.
  - par=1, syn≥CW_WIDTH: ded=1, data uncorrected.
  - par=0, syn≠0: ded=1, data passed uncorrected.
- Pipeline:
  - One register stage; latency is exactly 1 cycle from accept to out_valid_o.
  - in_ready_o = ~out_valid_o | out_ready_i.
  - Transfer occurs when valid&ready on a side.
  - On accept, data_o/sec_o/ded_o load. Otherwise they hold while out_valid_o=1 && !out_ready_i.
  - out_valid_o clears when the output is consumed with no new accept.
  - Simultaneous consume and accept: the new word loads and out_valid_o stays 1 (full throughput, no bubble).
- Counters:
  - Increment by 1 when an accepted word is classified sec/ded (counted at accept, not at output).
  - Saturate at all-ones.
  - Sticky flags set on the same event.
  - clear_i has priority over a same-cycle event: result is 0, and the event is lost.
- Reset values:
  - out_valid_o=0, data_o=0, sec_o=0, ded_o=0.
  - Counters 0, stickies 0.
  - in_ready_o=1 after reset.
  - Reset mid-transfer discards the held word.
- in_valid_i low: no counter activity.
- hv_i content is don't-care when in_valid_i=0.

Optional Feature:
HAMMING_SECDED_ERR_LOG_EN.
- When defined, add two outputs:
  - err_syn_o [N_CHECKB-1:0]: syndrome of the first SEC/DED word since clear.
  - err_log_valid_o: log holds a valid entry.
- The log freezes until clear_i; clear_i and reset zero both outputs.
- When undefined, these ports and registers do not exist.
- All other behaviour is identical in both cases.

Decomposition:
- Package hamming_secded_pkg holds:
  - function calc_checkb(width) for N_CHECKB.
  - function data_pos(i) mapping data index to codeword position.
  - typedef enum {CLEAN, SEC, DED} ecc_class_t.
- Natural sub-module: hamming_secded_core, combinational, param DATA_WIDTH, outputs data/sec/ded/syndrome.
- A future encoder shares the package.

Test Plan:
- DATA_WIDTH=11:
  - hv_i=16'hFFFF (encodes 11'h7FF) → next cycle data_o=11'h7FF, sec_o=0, ded_o=0, counters 0.
  - hv_i=16'h0008 (bit 3 flipped on zero word) → data_o=11'h000, sec_o=1, sec_cnt_o=1, sec_sticky_o=1.
  - hv_i=16'h0001 → data_o=0, sec_o=1. hv_i=16'h0018 (two flips) → ded_o=1, ded_cnt_o=1, data_o=11'h001 uncorrected.
- Backpressure:
  - out_ready_i=0 for 3 cycles while in_valid_i=1 → in_ready_o=0 and data_o holds the first word.
  - Release → words emerge in order, none lost or duplicated.
- Counters:
  - COUNT_WIDTH=2: five SEC words → sec_cnt_o=3 (saturated).
  - clear_i asserted in the same cycle as a SEC accept → sec_cnt_o=0, sticky=0.
- Reset and wide config:
  - rst_i asserted with out_valid_o=1 → next cycle out_valid_o=0, counters 0.
  - DATA_WIDTH=32 random single flips → all corrected.
